// File: rtl/f_fetch_ctrl.sv
`default_nettype none
// f_fetch_ctrl: fetch sequencer (PC control, single-outstanding IM handshake, F/D register with skid).
// Optional fetch address-error check enabled by defining F_FETCH_ADEL_EN.
module f_fetch_ctrl #(
  parameter logic [31:0] EXC_PC = 32'h00004180,
  parameter logic [31:0] PC_LO  = 32'h00003000,
  parameter logic [31:0] PC_HI  = 32'h00006ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] npc,
  output logic        halt,
  output logic        req,
  output logic        im_req,
  output logic [31:0] im_addr,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  output logic        fd_valid,
  output logic        fd_exc_adel
);

`ifdef F_FETCH_ADEL_EN
  localparam logic ADEL_EN = 1'b1;
`else
  localparam logic ADEL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic        fd_valid_q, fd_valid_d;
  logic        fd_adel_q, fd_adel_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_adel_q, buf_adel_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        br_done_q, br_done_d;

  logic        flush, bad_addr, adel, comp, br_eff;
  logic [31:0] cap_instr;

  always_comb begin
    flush     = exc_req | eret_req;
    bad_addr  = (pc[1:0] != 2'b00) || (pc < PC_LO) || (pc > PC_HI);
    adel      = ADEL_EN && (state_q == S_FETCH) && bad_addr;
    comp      = (state_q == S_FETCH) && !flush && (im_ack || adel);
    // A branch already redirected while it sits stalled in D must not redirect twice.
    br_eff    = br_taken && !br_done_q;
    cap_instr = adel ? 32'h0 : im_rdata;
  end

  always_comb begin
    req     = exc_req;
    halt    = !(comp || (eret_req && !exc_req));
    im_req  = ((state_q == S_FETCH) && !adel) || (state_q == S_DRAIN);
    im_addr = (state_q == S_DRAIN) ? drain_addr_q : pc;
    if (exc_req)       npc = EXC_PC;
    else if (eret_req) npc = epc;
    else if (br_eff)   npc = br_target;
    else if (pend_v_q) npc = pend_tgt_q;
    else               npc = pc + 32'd4;
  end

  always_comb begin
    state_d      = state_q;
    fd_instr_d   = fd_instr_q;
    fd_pc_d      = fd_pc_q;
    fd_valid_d   = fd_valid_q;
    fd_adel_d    = fd_adel_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    buf_adel_d   = buf_adel_q;
    pend_v_d     = pend_v_q;
    pend_tgt_d   = pend_tgt_q;
    drain_addr_d = drain_addr_q;
    br_done_d    = stall && !flush && (br_done_q || (comp && (br_eff || pend_v_q)));

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (flush) begin
          if (im_ack || adel) begin
            state_d = S_FETCH;
          end else begin
            state_d      = S_DRAIN;
            drain_addr_d = pc;
          end
        end else if (comp && stall) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD:  if (flush || !stall) state_d = S_FETCH;
      S_DRAIN: if (im_ack) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      fd_valid_d = 1'b0;
      pend_v_d   = 1'b0;
      buf_instr_d = 32'h0;
      buf_pc_d    = 32'h0;
      buf_adel_d  = 1'b0;
    end else begin
      if (comp && stall) begin
        buf_instr_d = cap_instr;
        buf_pc_d    = pc;
        buf_adel_d  = adel;
      end else if (comp) begin
        fd_instr_d = cap_instr;
        fd_pc_d    = pc;
        fd_valid_d = 1'b1;
        fd_adel_d  = adel;
      end else if ((state_q == S_HOLD) && !stall) begin
        fd_instr_d = buf_instr_q;
        fd_pc_d    = buf_pc_q;
        fd_valid_d = 1'b1;
        fd_adel_d  = buf_adel_q;
      end else if (!stall) begin
        fd_valid_d = 1'b0;
      end

      if (comp) begin
        pend_v_d = 1'b0;
      end else if (br_eff) begin
        pend_v_d   = 1'b1;
        pend_tgt_d = br_target;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      fd_instr_q   <= 32'h0;
      fd_pc_q      <= 32'h0;
      fd_valid_q   <= 1'b0;
      fd_adel_q    <= 1'b0;
      buf_instr_q  <= 32'h0;
      buf_pc_q     <= 32'h0;
      buf_adel_q   <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_tgt_q   <= 32'h0;
      drain_addr_q <= 32'h0;
      br_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fd_instr_q   <= fd_instr_d;
      fd_pc_q      <= fd_pc_d;
      fd_valid_q   <= fd_valid_d;
      fd_adel_q    <= fd_adel_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      buf_adel_q   <= buf_adel_d;
      pend_v_q     <= pend_v_d;
      pend_tgt_q   <= pend_tgt_d;
      drain_addr_q <= drain_addr_d;
      br_done_q    <= br_done_d;
    end
  end

  assign fd_instr    = fd_instr_q;
  assign fd_pc       = fd_pc_q;
  assign fd_valid    = fd_valid_q;
  assign fd_exc_adel = fd_adel_q;

endmodule
`default_nettype wire

// File: tb/tb_f_fetch_ctrl.sv
`default_nettype none
// tb_f_fetch_ctrl: directed checks of sequential fetch, stall/skid, delay slot, exception, eret.
module tb_f_fetch_ctrl;

  logic        clk, reset;
  logic [31:0] pc, epc, br_target, im_rdata;
  logic        stall, exc_req, eret_req, br_taken, im_ack;
  logic [31:0] npc, im_addr, fd_instr, fd_pc;
  logic        halt, req, im_req, fd_valid, fd_exc_adel;

  int n_cmp = 0;
  int n_err = 0;

  f_fetch_ctrl dut (
    .clk(clk), .reset(reset), .pc(pc), .stall(stall),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .br_taken(br_taken), .br_target(br_target),
    .im_ack(im_ack), .im_rdata(im_rdata),
    .npc(npc), .halt(halt), .req(req), .im_req(im_req), .im_addr(im_addr),
    .fd_instr(fd_instr), .fd_pc(fd_pc), .fd_valid(fd_valid), .fd_exc_adel(fd_exc_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are stable afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; pc = 32'h3000; stall = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
    epc = 32'h0; br_taken = 1'b0; br_target = 32'h0; im_ack = 1'b0; im_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fd_valid", fd_valid, 1'b0);
    chk("rst_fd_pc", fd_pc, 32'h0);
    chk("rst_fd_instr", fd_instr, 32'h0);
    chk("rst_fd_adel", fd_exc_adel, 1'b0);
    chk("rst_im_req", im_req, 1'b0);
    chk("rst_halt", halt, 1'b1);
    reset = 1'b1;
    #1 chk("idle_im_req", im_req, 1'b0);

    // Sequential fetch, ack two cycles after request.
    tick();
    #1 chk("f0_im_req", im_req, 1'b1);
    chk("f0_addr", im_addr, 32'h3000);
    chk("f0_halt", halt, 1'b1);
    tick();
    chk("f0_wait_valid", fd_valid, 1'b0);
    im_ack = 1'b1; im_rdata = 32'hA000_0000;
    #1 chk("f0_ack_halt", halt, 1'b0);
    chk("f0_npc", npc, 32'h3004);
    tick();
    chk("f0_fd_valid", fd_valid, 1'b1);
    chk("f0_fd_pc", fd_pc, 32'h3000);
    chk("f0_fd_instr", fd_instr, 32'hA000_0000);
    im_ack = 1'b0; pc = 32'h3004;
    #1 chk("f1_addr", im_addr, 32'h3004);
    chk("f1_halt", halt, 1'b1);
    tick();
    chk("f1_bubble", fd_valid, 1'b0);
    im_ack = 1'b1; im_rdata = 32'hA000_0001;
    #1 chk("f1_npc", npc, 32'h3008);
    tick();
    chk("f1_fd_pc", fd_pc, 32'h3004);
    chk("f1_fd_valid", fd_valid, 1'b1);

    // Completion while stalled goes to HOLD; F/D holds until stall drops.
    pc = 32'h3008; stall = 1'b1; im_rdata = 32'hA000_0002;
    #1 chk("st_halt", halt, 1'b0);
    chk("st_npc", npc, 32'h300c);
    tick();
    chk("st_fd_pc_hold", fd_pc, 32'h3004);
    chk("st_fd_valid_hold", fd_valid, 1'b1);
    im_ack = 1'b0; pc = 32'h300c;
    #1 chk("hold_halt", halt, 1'b1);
    chk("hold_im_req", im_req, 1'b0);
    tick();
    chk("hold2_fd_pc", fd_pc, 32'h3004);
    stall = 1'b0;
    #1 chk("hold_rel_halt", halt, 1'b1);
    tick();
    chk("unhold_fd_pc", fd_pc, 32'h3008);
    chk("unhold_fd_instr", fd_instr, 32'hA000_0002);
    chk("unhold_fd_valid", fd_valid, 1'b1);
    chk("unhold_im_req", im_req, 1'b1);
    chk("unhold_addr", im_addr, 32'h300c);

    // Branch in F/D while its delay slot is still fetching.
    br_taken = 1'b1; br_target = 32'h3100;
    #1 chk("br_npc", npc, 32'h3100);
    chk("br_halt", halt, 1'b1);
    tick();
    chk("br_bubble", fd_valid, 1'b0);
    br_taken = 1'b0;
    #1 chk("pend_npc", npc, 32'h3100);
    im_ack = 1'b1; im_rdata = 32'hA000_0003;
    #1 chk("ds_halt", halt, 1'b0);
    chk("ds_npc", npc, 32'h3100);
    tick();
    chk("ds_fd_pc", fd_pc, 32'h300c);
    im_ack = 1'b0; pc = 32'h3100;
    #1 chk("tgt_addr", im_addr, 32'h3100);
    chk("pend_cleared_npc", npc, 32'h3104);
    im_ack = 1'b1; im_rdata = 32'hA000_0004;
    tick();
    chk("tgt_fd_pc", fd_pc, 32'h3100);
    im_ack = 1'b0; pc = 32'h3104;

    // Exception mid-fetch with a pending branch: drain, discard, resume at EXC_PC.
    br_taken = 1'b1; br_target = 32'h3200;
    tick();
    br_taken = 1'b0; exc_req = 1'b1;
    #1 chk("exc_req", req, 1'b1);
    chk("exc_halt", halt, 1'b1);
    chk("exc_addr", im_addr, 32'h3104);
    tick();
    chk("exc_fd_valid", fd_valid, 1'b0);
    exc_req = 1'b0; pc = 32'h4180;
    #1 chk("drain_im_req", im_req, 1'b1);
    chk("drain_addr", im_addr, 32'h3104);
    chk("drain_req_low", req, 1'b0);
    im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF;
    #1 chk("drain_halt", halt, 1'b1);
    tick();
    chk("drain_discard", fd_valid, 1'b0);
    im_ack = 1'b0;
    #1 chk("exc_fetch_addr", im_addr, 32'h4180);
    chk("exc_pend_cleared", npc, 32'h4184);
    im_ack = 1'b1; im_rdata = 32'hA000_0005;
    tick();
    chk("exc_fd_pc", fd_pc, 32'h4180);
    chk("exc_fd_instr", fd_instr, 32'hA000_0005);

    // Eret while an instruction waits in the skid buffer.
    pc = 32'h4184; stall = 1'b1; im_rdata = 32'hA000_0006;
    tick();
    im_ack = 1'b0; pc = 32'h4188; eret_req = 1'b1; epc = 32'h3020;
    #1 chk("eret_npc", npc, 32'h3020);
    chk("eret_halt", halt, 1'b0);
    chk("eret_req_low", req, 1'b0);
    tick();
    chk("eret_fd_valid", fd_valid, 1'b0);
    eret_req = 1'b0; stall = 1'b0; pc = 32'h3020;
    #1 chk("eret_addr", im_addr, 32'h3020);
    im_ack = 1'b1; im_rdata = 32'hA000_0007;
    tick();
    chk("eret_fd_pc", fd_pc, 32'h3020);
    chk("eret_fd_instr", fd_instr, 32'hA000_0007);
    im_ack = 1'b0; pc = 32'h3024;
    tick();
    chk("eret_buf_dropped", fd_valid, 1'b0);

    // Flush coinciding with ack: data dropped, no drain.
    exc_req = 1'b1; im_ack = 1'b1; im_rdata = 32'hBAD0_0000;
    tick();
    exc_req = 1'b0; im_ack = 1'b0; pc = 32'h4180;
    #1 chk("flush_ack_addr", im_addr, 32'h4180);
    chk("flush_ack_valid", fd_valid, 1'b0);

    // Exception outranks eret.
    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3040;
    #1 chk("prio_req", req, 1'b1);
    chk("prio_halt", halt, 1'b1);
    tick();
    exc_req = 1'b0; eret_req = 1'b0; im_ack = 1'b1;
    tick();
    im_ack = 1'b0;

`ifdef F_FETCH_ADEL_EN
    pc = 32'h3002; im_rdata = 32'h1234_5678;
    #1 chk("adel_mis_im_req", im_req, 1'b0);
    chk("adel_mis_halt", halt, 1'b0);
    tick();
    chk("adel_mis_flag", fd_exc_adel, 1'b1);
    chk("adel_mis_instr", fd_instr, 32'h0);
    chk("adel_mis_pc", fd_pc, 32'h3002);
    chk("adel_mis_valid", fd_valid, 1'b1);
    pc = 32'h7000;
    #1 chk("adel_hi_im_req", im_req, 1'b0);
    tick();
    chk("adel_hi_flag", fd_exc_adel, 1'b1);
    chk("adel_hi_pc", fd_pc, 32'h7000);
    pc = 32'h3010; im_ack = 1'b1; im_rdata = 32'hA000_0008;
    tick();
    chk("adel_clear", fd_exc_adel, 1'b0);
    chk("adel_ok_instr", fd_instr, 32'hA000_0008);
`else
    pc = 32'h3002; im_rdata = 32'hA000_0008;
    #1 chk("noadel_im_req", im_req, 1'b1);
    im_ack = 1'b1;
    tick();
    chk("noadel_flag", fd_exc_adel, 1'b0);
    chk("noadel_pc", fd_pc, 32'h3002);
`endif
    im_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/f_fetch_ctrl.md
Name: f_fetch_ctrl

Overview:
- Fetch-stage sequencer. Drives the PC register's control inputs (nPc, halt, req).
- Runs a single-outstanding req/ack handshake to instruction memory.
- Holds the F/D instruction register, with a one-entry skid buffer for downstream stalls.
- Arbitrates redirect sources, highest priority first: exception > eret > branch (delay-slot aware) > sequential.

Parameters:
- EXC_PC, 32'h00004180, exception entry address (matches PC register's req target)
- PC_LO, 32'h00003000, lowest legal fetch address (ADEL check only)
- PC_HI, 32'h00006ffc, highest legal fetch address (ADEL check only)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- pc  in  32  current PC from PC register
- stall  in  1  hazard unit: hold F/D register
- exc_req  in  1  exception flush, redirect to EXC_PC
- eret_req  in  1  eret flush, redirect to epc
- epc  in  32  eret target
- br_taken  in  1  D-stage branch/jump taken
- br_target  in  32  branch/jump target
- im_ack  in  1  instruction memory response valid
- im_rdata  in  32  instruction word
- npc  out  32  next PC to PC register
- halt  out  1  PC register hold
- req  out  1  PC register exception load (= exc_req, combinational)
- im_req  out  1  memory request
- im_addr  out  32  memory address
- fd_instr  out  32  F/D instruction (registered)
- fd_pc  out  32  F/D PC (registered)
- fd_valid  out  1  F/D valid (registered)
- fd_exc_adel  out  1  F/D fetch address error (registered)

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; fd_instr=0, fd_pc=0, fd_valid=0, fd_exc_adel=0.
  - pend_v=0; buffer empty.
- States and transitions:
  - IDLE→FETCH unconditionally, one cycle after reset release.
  - FETCH→HOLD: ack while stall=1.
  - HOLD→FETCH: when stall=0.
  - FETCH→DRAIN: flush with no ack in the same cycle.
  - DRAIN→FETCH: on im_ack.
- Memory handshake:
  - im_req=1 in FETCH and DRAIN only.
  - im_req and im_addr stay stable until im_ack; one request outstanding; responses in order.
  - im_addr = pc in FETCH; = drain_addr (pc latched at kill) in DRAIN.
- Fetch completion (FETCH, im_ack=1, no flush):
  - stall=0: fd_instr<=im_rdata, fd_pc<=pc, fd_valid<=1, halt=0.
  - stall=1: capture into buffer, halt=0, →HOLD.
- HOLD:
  - halt=1; im_req=0.
  - When stall=0: fd<=buffer, buffer emptied, →FETCH.
- Idle F/D updates:
  - stall=0 with no completion that cycle: fd_valid<=0 (bubble).
  - stall=1: all fd_* hold.
- halt=1 in all cases except fetch completion or eret.
- npc priority: eret_req ? epc : br_taken ? br_target : pend_v ? pend_tgt : pc+4 (wrap mod 2^32).
- Delay slot:
  - br_taken refers to the instruction in F/D; the instruction at pc is its delay slot and is fetched normally.
  - br_taken with no advance this cycle: pend_v<=1, pend_tgt<=br_target.
  - Cleared on the next advance, which uses the target. A repeated br_taken during stall is idempotent.
- Flush (exc_req or eret_req):
  - fd_valid<=0; pend_v<=0; buffer cleared.
  - Outstanding request: if im_ack is also 1, drop the data and →FETCH; else latch drain_addr and →DRAIN. Drained data is discarded.
  - eret forces halt=0, npc=epc.
  - exc: req=1 (PC register loads EXC_PC; npc don't-care).
  - exc_req wins if both are asserted.
  - Flush in HOLD/IDLE: →FETCH.
- Reset mid-request: state returns to IDLE; memory-side cleanup is not this block's concern.

Optional Feature:
- Macro: F_FETCH_ADEL_EN.
- Defined: in FETCH, if pc[1:0]!=0 or pc<PC_LO or pc>PC_HI, no im_req is issued. Treated as a completion in the same cycle (im_ack not required): fd_instr<=0, fd_exc_adel<=1, fd_pc<=pc. Stall/HOLD rules apply unchanged.
- Undefined: no check, fd_exc_adel constant 0, PC_LO/PC_HI unused.

Test Plan:
- Sequential: reset release, pc=3000, ack after 2 cycles each → fd_pc 3000,3004,3008; fd_valid=1 only in completion cycles; npc=pc+4.
- Stall: ack for 3004 while stall=1 → HOLD, halt=1, fd holds 3000. Release stall → fd_pc=3004, fetch of 3008 begins.
- Delay slot: fd=3000 branch, br_taken=1, target 3100, fetch of 3004 incomplete → pend_v=1. On ack of 3004: npc=3100, next fd_pc 3004 then 3100.
- Exception mid-fetch: exc_req at pc=3008, no ack → req=1, DRAIN with im_addr=3008. Drained ack discarded (fd_valid=0). Next fetch at 4180, pend_v cleared.
- Eret: eret_req, epc=3020, during HOLD → buffer dropped, fd_valid=0, npc=3020, halt=0, next fd_pc=3020.
- F_FETCH_ADEL_EN: pc=3002 → im_req=0, fd_exc_adel=1, fd_instr=0 next cycle. pc=7000 → same.
